// File: rtl/mcdf_slave_node.sv
//------------------------------------------------------------------------------
// Module      : mcdf_slave_node
// Description : MCDF channel-side slave stage. It takes words from a channel
//               over valid/ready, buffers them in a wrap-bit pointer FIFO, and
//               serves them to the arbiter over request/acknowledge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mcdf_slave_node #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          slv_en_i,
    input  logic [DW-1:0] ch_data_i,
    input  logic          ch_valid_i,
    output logic          ch_ready_o,
    input  logic          a2s_ack_i,
    output logic          slv_req_o,
    output logic          slv_val_o,
    output logic [DW-1:0] slv_data_o,
    output logic [AW:0]   margin_o
);

    localparam logic [AW:0] c_depth = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] c_one   = {{AW{1'b0}}, 1'b1};

    logic [DW-1:0] r_mem [2**AW];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          r_val;
    logic [DW-1:0] r_data;

    logic          w_empty;
    logic          w_full;
    logic [AW:0]   w_count;
    logic          w_wr_fire;
    logic          w_rd_fire;

    // The extra MSB of each pointer separates full (same slot, different lap)
    // from empty (same slot, same lap).
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_count   = r_wr_ptr - r_rd_ptr;

    assign ch_ready_o = slv_en_i & ~w_full;
    assign slv_req_o  = slv_en_i & ~w_empty;
    assign margin_o   = c_depth - w_count;

    assign w_wr_fire = ch_valid_i & ch_ready_o;
    assign w_rd_fire = a2s_ack_i & slv_req_o;

    always_ff @(posedge clk) begin
        if (w_wr_fire && !rst) begin
            r_mem[r_wr_ptr[AW-1:0]] <= ch_data_i;
        end
    end

    // A read fired in the same cycle as reset is dropped along with the contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_val    <= 1'b0;
            r_data   <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + c_one;
            end
            if (w_rd_fire) begin
                r_data   <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr <= r_rd_ptr + c_one;
            end
            r_val <= w_rd_fire;
        end
    end

    assign slv_val_o  = r_val;
    assign slv_data_o = r_data;

endmodule

`default_nettype wire

// File: tb/tb_mcdf_slave_node.sv
//------------------------------------------------------------------------------
// Module      : tb_mcdf_slave_node
// Description : Self-checking bench for mcdf_slave_node; a behavioural FIFO
//               model feeds an expected-data queue drained by a monitor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mcdf_slave_node;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int c_depth = 2**AW;

    logic          clk;
    logic          rst;
    logic          slv_en_i;
    logic [DW-1:0] ch_data_i;
    logic          ch_valid_i;
    logic          ch_ready_o;
    logic          a2s_ack_i;
    logic          slv_req_o;
    logic          slv_val_o;
    logic [DW-1:0] slv_data_o;
    logic [AW:0]   margin_o;

    mcdf_slave_node #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .slv_en_i   (slv_en_i),
        .ch_data_i  (ch_data_i),
        .ch_valid_i (ch_valid_i),
        .ch_ready_o (ch_ready_o),
        .a2s_ack_i  (a2s_ack_i),
        .slv_req_o  (slv_req_o),
        .slv_val_o  (slv_val_o),
        .slv_data_o (slv_data_o),
        .margin_o   (margin_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mdl_q [$];
    logic [DW-1:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // One cycle: drive inputs, check status against the model, then clock.
    task automatic step(input logic en, input logic valid, input logic ack,
                        input logic [DW-1:0] data, input logic do_rst);
        logic wfire;
        logic rfire;
        slv_en_i   = en;
        ch_valid_i = valid;
        a2s_ack_i  = ack;
        ch_data_i  = data;
        rst        = do_rst;
        #1;
        chk("ch_ready", 64'(ch_ready_o), 64'(en && mdl_q.size() < c_depth));
        chk("slv_req",  64'(slv_req_o),  64'(en && mdl_q.size() > 0));
        chk("margin",   64'(margin_o),   64'(c_depth - mdl_q.size()));
        wfire = valid && en && (mdl_q.size() < c_depth);
        rfire = ack && en && (mdl_q.size() > 0);
        @(posedge clk);
        if (do_rst) begin
            mdl_q.delete();
            exp_q.delete();
        end else begin
            if (rfire) exp_q.push_back(mdl_q.pop_front());
            if (wfire) mdl_q.push_back(data);
        end
        #1;
    endtask

    // Each word queued at an edge must appear on slv_val_o/slv_data_o by the next negedge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                chk("slv_val", 64'(slv_val_o), 64'(1));
                chk("slv_data", 64'(slv_data_o), 64'(e));
            end else if (slv_val_o !== 1'b0 && !rst) begin
                chk("slv_val_idle", 64'(slv_val_o), 64'(0));
            end
        end
    end

    initial begin
        rst = 1'b1; slv_en_i = 1'b1; ch_valid_i = 1'b0; a2s_ack_i = 1'b0; ch_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_val", 64'(slv_val_o), 64'(0));
        chk("reset_data", 64'(slv_data_o), 64'(0));
        step(1, 0, 0, 0, 0);

        // Fill to full, then offer a word that must be refused.
        for (int i = 0; i < 32; i++) step(1, 1, 0, 32'(i), 0);
        chk("full_ready", 64'(ch_ready_o), 64'(0));
        chk("full_margin", 64'(margin_o), 64'(0));
        step(1, 1, 0, 32'hAA, 0);
        step(1, 0, 0, 0, 0);

        // Drain, plus one ack on an empty FIFO.
        for (int i = 0; i < 32; i++) step(1, 0, 1, 0, 0);
        chk("empty_req", 64'(slv_req_o), 64'(0));
        chk("empty_margin", 64'(margin_o), 64'(32));
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);

        // Streaming with one word resident across several pointer wraps.
        step(1, 1, 0, 32'h100, 0);
        for (int i = 0; i < 100; i++) step(1, 1, 1, 32'h200 + 32'(i), 0);
        chk("stream_margin", 64'(margin_o), 64'(31));
        step(1, 0, 1, 0, 0);

        // Disabled node holds its five words.
        for (int i = 0; i < 5; i++) step(1, 1, 0, 32'h300 + 32'(i), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 32'hDEAD, 0);
        chk("dis_margin", 64'(margin_o), 64'(27));
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0);

        // Reset coincident with a read fire.
        for (int i = 0; i < 10; i++) step(1, 1, 0, 32'h400 + 32'(i), 0);
        step(1, 0, 1, 0, 1);
        chk("rst_val", 64'(slv_val_o), 64'(0));
        chk("rst_margin", 64'(margin_o), 64'(32));
        chk("rst_req", 64'(slv_req_o), 64'(0));
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mcdf_slave_node.md
# mcdf_slave_node

Channel-side slave stage of the MCDF datapath. Accepts words from one channel over a valid/ready handshake, buffers them in a synchronous FIFO whose full/empty/margin status comes from wrap-bit pointer comparison, and presents them to the downstream arbiter as a request/acknowledge source. It sits between the channel interface and the arbiter, and it is the consumer of the slave-FIFO pointer comparators.

## Interface
- DW, 32, data width in bits
- AW, 5, FIFO address width; depth = 2**AW (32 words)

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous active-high reset
- slv_en_i  in  1  slave enable; when low, no accepts and no requests (FIFO contents held)
- ch_data_i  in  DW  channel write data
- ch_valid_i  in  1  channel data valid
- ch_ready_o  out  1  node can accept a word this cycle
- a2s_ack_i  in  1  arbiter grants/pops one word this cycle
- slv_req_o  out  1  node has data and requests service
- slv_val_o  out  1  slv_data_o valid (one cycle after accepted ack)
- slv_data_o  out  DW  popped word
- margin_o  out  AW+1  free entries, 0..2**AW

## Operation
- Storage: 2**AW x DW register array. wr_ptr and rd_ptr are AW+1 bits and include a wrap bit.
- empty = (wr_ptr == rd_ptr). full = low AW bits equal and MSBs differ.
- count = wr_ptr - rd_ptr, computed modulo 2**(AW+1). margin_o = 2**AW - count, taken from registered pointers.
- ch_ready_o = slv_en_i & ~full. This is combinational from registered state and does not depend on ch_valid_i.
- Write fire = ch_valid_i & ch_ready_o. On fire, mem[wr_ptr[AW-1:0]] <= ch_data_i and wr_ptr increments.
- slv_req_o = slv_en_i & ~empty (combinational).
- Read fire = a2s_ack_i & slv_req_o. On fire, slv_data_o <= mem[rd_ptr[AW-1:0]], slv_val_o <= 1 on the next edge, and rd_ptr increments.
- When there is no read fire: slv_val_o <= 0 and slv_data_o holds its last value.
- a2s_ack_i while slv_req_o is low is ignored: no pointer move, slv_val_o = 0.
- Simultaneous write and read fire: both happen and count is unchanged. When full, ready is already low, so only the read proceeds. When empty, req is low, so only the write proceeds; the new word is not bypassed.
- Pointer wrap: past 2**(AW+1)-1, a pointer rolls to 0. Status stays correct through any number of wraps.
- slv_en_i deassertion blocks new accepts and requests from the next evaluation. It does not cancel a read already fired, whose slv_val_o still appears.

## Timing
- Reset (rst=1 at an edge): wr_ptr=rd_ptr=0, slv_val_o=0, slv_data_o=0. Resulting outputs: ch_ready_o=slv_en_i, slv_req_o=0, margin_o=2**AW.
- Reset asserted mid-transfer discards all contents and any pending slv_val_o. Memory array contents need not be cleared.
- Write-to-request latency: a word accepted at edge N raises slv_req_o after edge N (visible in cycle N+1) if the FIFO was empty.
- Ack-to-data latency: 1 cycle. An ack sampled at edge N gives slv_val_o=1 and slv_data_o valid during cycle N+1.
- Back-to-back acks yield one word per cycle.
- margin_o and full/empty update one edge after the fire that changes them. No fire-dependent combinational path exists from ch_valid_i or a2s_ack_i to any output.

## Test plan
- Reset then idle, slv_en_i=1 -> ch_ready_o=1, slv_req_o=0, slv_val_o=0, margin_o=32.
- Write 32 words 0x00..0x1F back-to-back -> after word 32, ch_ready_o=0 and margin_o=0. A 33rd valid word 0xAA is not accepted and the pointers are unchanged.
- Ack 32 cycles from full -> slv_val_o high for 32 consecutive cycles, each one cycle after its ack, with data 0x00..0x1F in order. Afterwards slv_req_o=0 and margin_o=32. A further ack gives slv_val_o=0.
- Continuous simultaneous write and ack for 100 cycles starting with 1 word stored -> margin_o stays 31 and output order matches input order, covering more than 3 pointer wraps.
- slv_en_i=0 with 5 words stored and ch_valid_i=1, a2s_ack_i=1 -> ch_ready_o=0, slv_req_o=0, no pointer movement, margin_o=27. Re-enabling resumes output with the 1st stored word.
- rst pulsed the same cycle as a read fire with 10 words stored -> next cycle slv_val_o=0, margin_o=32, slv_req_o=0.
